// File: rtl/conv_encoder_stream.sv
// conv_encoder_stream
//   Streaming rate-1/NOUT convolutional encoder with valid/ready handshakes on
//   both sides and a single output register stage (latency 1 cycle).
//   Supports feedforward (RECURSIVE == 0) or recursive (RECURSIVE != 0) codes.
//
//   Optional feature macro: CONV_ENC_TERMINATE_EN
//     defined   : after the in_last bit, STATE_BITS tail symbols are appended
//                 that drive the trellis back to state 0; out_tail marks them
//                 and out_last marks the final tail symbol.
//     undefined : no tail; out_last marks the symbol of the in_last bit, the
//                 state is zeroed after it and out_tail is tied low.
//
//   FSM (terminating build only):
//     state | meaning
//     DATA  | accepting information bits from the input stream
//     TAIL  | input blocked, emitting STATE_BITS termination symbols
//
// Ports
//   clk, reset           clock, synchronous active-high reset
//   in_valid/in_ready    input handshake; in_data is the bit, in_last ends frame
//   out_valid/out_ready  output handshake
//   out_data [NOUT]      coded symbol, bit NOUT-1-k from generator POLY[k]
//   out_last, out_tail   final symbol of frame / termination symbol flag
module conv_encoder_stream #(
  parameter int STATES        = 8,
  parameter int NOUT          = 2,
  parameter int RECURSIVE     = 0,
  parameter int POLY [NOUT]   = '{default: 0}
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NOUT-1:0] out_data,
  output logic            out_last,
  output logic            out_tail
);

  localparam int STATE_BITS = $clog2(STATES);
  localparam logic [STATE_BITS:0] REC_MASK = RECURSIVE[STATE_BITS:0];

  logic [STATE_BITS-1:0] state;
  logic [STATE_BITS-1:0] next_state;
  logic                  u_data;
  logic                  u_eff;
  logic [NOUT-1:0]       code;
  logic                  load_ok;
  logic                  accept;

  // The output register can take a new symbol when empty or draining now.
  assign load_ok = !out_valid | out_ready;
  assign accept  = in_valid & in_ready;

  always_comb begin
    if (RECURSIVE == 0) u_data = in_data;
    else                u_data = ^({in_data, state} & REC_MASK);
  end

`ifdef CONV_ENC_TERMINATE_EN
  localparam logic [0:0] FSM_DATA = 1'b0;
  localparam logic [0:0] FSM_TAIL = 1'b1;
  localparam int TCW = (STATE_BITS > 1) ? $clog2(STATE_BITS) : 1;

  logic [0:0]     fsm;
  logic [TCW-1:0] tail_cnt;
  logic           tail_load;

  assign in_ready  = (fsm == FSM_DATA) & load_ok;
  assign tail_load = (fsm == FSM_TAIL) & load_ok;
  // During the tail the input bit is chosen so that u_eff is 0, which is the
  // same as forcing u_eff to 0 directly; the trellis then flushes to 0.
  assign u_eff     = (fsm == FSM_TAIL) ? 1'b0 : u_data;
`else
  assign in_ready  = load_ok;
  assign u_eff     = u_data;
  assign out_tail  = 1'b0;
`endif

  assign next_state = {u_eff, state[STATE_BITS-1:1]};

  always_comb begin
    code = '0;
    for (int k = 0; k < NOUT; k++) begin
      code[NOUT-1-k] = ^({u_eff, state} & POLY[k][STATE_BITS:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
`ifdef CONV_ENC_TERMINATE_EN
      out_tail  <= 1'b0;
      fsm       <= FSM_DATA;
      tail_cnt  <= '0;
`endif
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= code;
      state     <= next_state;
`ifdef CONV_ENC_TERMINATE_EN
      out_last  <= 1'b0;
      out_tail  <= 1'b0;
      if (in_last) begin
        fsm      <= FSM_TAIL;
        tail_cnt <= '0;
      end
`else
      out_last  <= in_last;
      if (in_last) state <= '0;
`endif
    end
`ifdef CONV_ENC_TERMINATE_EN
    else if (tail_load) begin
      out_valid <= 1'b1;
      out_data  <= code;
      out_tail  <= 1'b1;
      state     <= next_state;
      if (tail_cnt == TCW'(STATE_BITS - 1)) begin
        out_last <= 1'b1;
        fsm      <= FSM_DATA;
        tail_cnt <= '0;
      end else begin
        out_last <= 1'b0;
        tail_cnt <= tail_cnt + 1'b1;
      end
    end
`endif
    else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_encoder_stream.sv
// tb_conv_encoder_stream
//   Drives a feedforward and a recursive instance with identical stimulus and
//   checks both against a behavioural trellis model through per-instance
//   expected-symbol queues popped by an independent output monitor.
module tb_conv_encoder_stream;

  localparam int SB     = 3;
  localparam int POLY0  = 'b1011;
  localparam int POLY1  = 'b1111;
  localparam int REC_R  = 'b1101;
`ifdef CONV_ENC_TERMINATE_EN
  localparam bit TERM = 1'b1;
`else
  localparam bit TERM = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] d;
    logic       l;
    logic       t;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_data, in_last, out_ready;
  logic [1:0] ir, ov, ol, ot;
  logic [1:0] od0, od1;

  always #5 clk = ~clk;

  conv_encoder_stream #(.STATES(8), .NOUT(2), .RECURSIVE(0), .POLY('{POLY0, POLY1})) dut_f (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od0),
    .out_last(ol[0]), .out_tail(ot[0]));

  conv_encoder_stream #(.STATES(8), .NOUT(2), .RECURSIVE(REC_R), .POLY('{POLY0, POLY1})) dut_r (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od1),
    .out_last(ol[1]), .out_tail(ot[1]));

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   st[2];
  bit   rdy_rand = 1'b0;
  bit   burst = 1'b0;
  int   gap_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference trellis step: u_eff from the input rule, outputs as generator
  // parities over {u_eff, state}, then shift u_eff in at the top.
  function automatic exp_t step(input int rec, input int u_in, input bit tail, inout int s);
    int   u, v;
    exp_t e;
    if (tail)          u = 0;
    else if (rec == 0) u = u_in;
    else               u = $countones(((u_in << SB) | s) & rec) & 1;
    v = (u << SB) | s;
    e.d[1] = ($countones(v & POLY0) & 1) != 0;
    e.d[0] = ($countones(v & POLY1) & 1) != 0;
    e.l = 1'b0;
    e.t = 1'b0;
    s = (u << (SB - 1)) | (s >> 1);
    return e;
  endfunction

  task automatic push(input int i, input exp_t e);
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic model_accept(input logic b, input logic l);
    exp_t e;
    int   s;
    for (int i = 0; i < 2; i++) begin
      s = st[i];
      e = step((i == 0) ? 0 : REC_R, int'(b), 1'b0, s);
      e.l = TERM ? 1'b0 : l;
      push(i, e);
      if (l) begin
        if (TERM) begin
          for (int j = 0; j < SB; j++) begin
            e = step(0, 0, 1'b1, s);
            e.t = 1'b1;
            e.l = (j == SB - 1);
            push(i, e);
          end
        end else begin
          s = 0;
        end
      end
      st[i] = s;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic l, output int waits);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    waits    = 0;
    forever begin
      @(negedge clk);
      if (ir[0]) break;
      waits++;
      if (waits > 100) break;
    end
    if (waits > 100) begin
      n_vec++;
      n_err++;
      $display("FAIL handshake_timeout: in_ready stayed %0b, expected 1 within 100 cycles", ir[0]);
    end else begin
      model_accept(b, l);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic flush_model();
    q0.delete();
    q1.delete();
    st[0] = 0;
    st[1] = 0;
  endtask

  // Random downstream back-pressure when enabled.
  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Output monitor: pops expectations on each transfer and checks stability
  // of a symbol held under back-pressure.
  logic [1:0] dsel;
  exp_t       cur, e_m;
  exp_t       held [2];
  bit         stall [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    if (reset) begin
      stall[0] = 1'b0;
      stall[1] = 1'b0;
    end else begin
      if (burst && !ov[0]) gap_cnt++;
      for (int i = 0; i < 2; i++) begin
        dsel = (i == 0) ? od0 : od1;
        cur  = '{d: dsel, l: ol[i], t: ot[i]};
        if (stall[i]) begin
          chk("hold_valid", int'(ov[i]), 1);
          chk("hold_symbol", int'(cur), int'(held[i]));
        end
        if (ov[i] && out_ready) begin
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_symbol dut%0d: got d=%b l=%b t=%b, expected no output", i, cur.d, cur.l, cur.t);
          end else begin
            e_m = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("sym_data dut%0d", i), int'(cur.d), int'(e_m.d));
            chk($sformatf("sym_last dut%0d", i), int'(cur.l), int'(e_m.l));
            chk($sformatf("sym_tail dut%0d", i), int'(cur.t), int'(e_m.t));
          end
        end
        stall[i] = ov[i] & !out_ready;
        held[i]  = cur;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int len;
    st[0] = 0;
    st[1] = 0;
    out_ready = 1'b1;
    idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_out_valid", int'(ov[i]), 0);
      chk("rst_out_last", int'(ol[i]), 0);
      chk("rst_out_tail", int'(ot[i]), 0);
      chk("rst_in_ready", int'(ir[i]), 1);
    end
    chk("rst_out_data0", int'(od0), 0);
    chk("rst_out_data1", int'(od1), 0);
    @(posedge clk);
    #1;

    // Frame 1,0 then single-bit frame 1
    send_bit(1'b1, 1'b0, w);
    send_bit(1'b0, 1'b1, w);
    idle();
    repeat (8) @(posedge clk);
    #1;
    send_bit(1'b1, 1'b1, w);
    idle();
    repeat (8) @(posedge clk);
    #1;

    // Back-pressure: first symbol held for 5 cycles
    send_bit(1'b1, 1'b0, w);
    idle();
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", int'(ir[0]), 0);
      chk("stall_valid", int'(ov[0]), 1);
      chk("stall_data_f", int'(od0), 'b11);
      chk("stall_data_r", int'(od1), 'b11);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send_bit(1'b0, 1'b0, w);
    send_bit(1'b1, 1'b0, w);
    send_bit(1'b1, 1'b1, w);
    idle();
    repeat (8) @(posedge clk);
    #1;

    // Continuous input across two frames
    gap_cnt = 0;
    for (int b = 0; b < 5; b++) begin
      send_bit(1'($urandom_range(0, 1)), b == 4, w);
      burst = 1'b1;
    end
    for (int b = 0; b < 4; b++) begin
      send_bit(1'($urandom_range(0, 1)), b == 3, w);
      if (b == 0) chk("tail_in_ready_low_cycles", w, TERM ? SB : 0);
    end
    burst = 1'b0;
    chk("burst_output_gaps", gap_cnt, 0);
    idle();
    repeat (8) @(posedge clk);
    #1;

    // Reset during second tail cycle (mid-frame in the non-terminating build)
    send_bit(1'b1, 1'b0, w);
    send_bit(1'b0, 1'b0, w);
    send_bit(1'b1, TERM, w);
    idle();
    @(posedge clk);
    #1 reset = 1'b1;
    flush_model();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midreset_valid_f", int'(ov[0]), 0);
    chk("midreset_valid_r", int'(ov[1]), 0);
    chk("midreset_last_f", int'(ol[0]), 0);
    chk("midreset_state_f", int'(dut_f.state), 0);
    chk("midreset_state_r", int'(dut_r.state), 0);
    chk("midreset_in_ready", int'(ir[0]), 1);
    @(posedge clk);
    #1;
    for (int b = 0; b < 4; b++) send_bit(1'($urandom_range(0, 1)), b == 3, w);
    idle();
    repeat (8) @(posedge clk);
    #1;

    // Randomised frames with random back-pressure and input gaps
    rdy_rand = 1'b1;
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 8);
      for (int b = 0; b < len; b++) begin
        send_bit(1'($urandom_range(0, 1)), b == len - 1, w);
        if ($urandom_range(0, 3) == 0) begin
          idle();
          repeat ($urandom_range(1, 2)) @(posedge clk);
          #1;
        end
      end
    end
    idle();
    rdy_rand = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int c = 0; c < 100 && (q0.size() != 0 || q1.size() != 0); c++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("pending_f", q0.size(), 0);
    chk("pending_r", q1.size(), 0);
    chk("end_state_f", int'(dut_f.state), 0);
    chk("end_state_r", int'(dut_r.state), 0);
    chk("end_valid", int'(ov[0]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
